// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit framer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic STOP_ONE  = 1'b0;
  localparam logic STOP_TWO  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity over the active low-order len bits of a data word.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CNT_W-1:0]      len,
  input  logic                  par_typ,
  output logic                  parity
);

  logic [DATA_WIDTH-1:0] mask;
  logic                  xor_all;

  // Bits at or above len do not take part in the parity.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign mask[gi] = (len > CNT_W'(gi));
    end
  endgenerate

  assign xor_all = ^(data & mask);
  assign parity  = (par_typ == PAR_EVEN) ? xor_all : ~xor_all;

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: start bit, len data bits, optional parity, 1 or 2 stop bits.
// All outputs are registered and are loaded with the value for the state being
// entered, so the start bit appears directly after the accepting edge.
module uart_tx_frame_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [CNT_W-1:0]      DATA_LEN,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DATA_ACK,
  output logic                  FRAME_DONE
);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [CNT_W-1:0]      len_reg, len_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  stop2_reg, stop2_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  ack_reg, ack_next;
  logic                  done_reg, done_next;

  logic                  parity_bit;
  logic                  accept;
  logic                  final_stop;
  logic [CNT_W-1:0]      stop_last;
  logic [CNT_W-1:0]      len_in;
  logic [CNT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shifted;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_parity (
    .data    (data_reg),
    .len     (len_reg),
    .par_typ (par_typ_reg),
    .parity  (parity_bit)
  );

  // State, counter, latched frame config and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      data_reg    <= '0;
      len_reg     <= CNT_W'(DATA_WIDTH);
      par_en_reg  <= 1'b0;
      par_typ_reg <= PAR_EVEN;
      stop2_reg   <= STOP_ONE;
      tx_reg      <= IDLE_LVL;
      busy_reg    <= 1'b0;
      ack_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      len_reg     <= len_next;
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
      stop2_reg   <= stop2_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
    end
  end

  // Next state, config latch on acceptance, and output values for the next state.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    len_next     = len_reg;
    par_en_next  = par_en_reg;
    par_typ_next = par_typ_reg;
    stop2_next   = stop2_reg;
    tx_next      = IDLE_LVL;
    bit_idx      = '0;
    shifted      = '0;

    // Last stop cycle index: 0 for one stop bit, 1 for two.
    stop_last  = (stop2_reg == STOP_TWO) ? CNT_W'(1) : CNT_W'(0);
    final_stop = (state_reg == STOP) && (cnt_reg == stop_last);
    accept     = DATA_VALID && ((state_reg == IDLE) || final_stop);

    // Zero or oversize lengths fall back to the full word width.
    len_in = ((DATA_LEN == '0) || (DATA_LEN > CNT_W'(DATA_WIDTH))) ?
             CNT_W'(DATA_WIDTH) : DATA_LEN;

    if (accept) begin
      data_next    = P_DATA;
      len_next     = len_in;
      par_en_next  = PAR_EN;
      par_typ_next = PAR_TYP;
      stop2_next   = STOP2;
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        state_next = DATA;
        cnt_next   = '0;
      end
      DATA: begin
        if (cnt_reg == len_reg - CNT_W'(1)) begin
          state_next = par_en_reg ? PARITY : STOP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PARITY: begin
        state_next = STOP;
        cnt_next   = '0;
      end
      STOP: begin
        if (final_stop) begin
          state_next = accept ? START : IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Data bits only go out after START, by which time data_reg is latched.
    bit_idx = MSB_FIRST ? (len_reg - cnt_next - CNT_W'(1)) : cnt_next;
    shifted = data_reg >> bit_idx;

    case (state_next)
      START:   tx_next = START_LVL;
      DATA:    tx_next = shifted[0];
      PARITY:  tx_next = parity_bit;
      default: tx_next = IDLE_LVL;
    endcase

    busy_next = (state_next != IDLE);
    ack_next  = accept;
    done_next = (state_next == STOP) && (cnt_next == stop_last);
  end

  assign TX_OUT     = tx_reg;
  assign BUSY       = busy_reg;
  assign DATA_ACK   = ack_reg;
  assign FRAME_DONE = done_reg;

endmodule
